time_set_controller: RTL and testbench

- Consumes the single-cycle button pulses (up/down/left/right/center) produced by the debounced push-button front end of the alarm clock.
- Holds the time-of-day and alarm registers, and advances time on a per-minute tick from the timebase.
- Runs the mode/field-select state machine for editing time and alarm, and raises the alarm ring flag.
- Outputs feed the display mux and the buzzer driver.

---
 rtl/time_set_controller.sv | 213 +++++++++++++++++++++
 tb/tb_time_set_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// Alarm clock time/alarm registers, edit-mode FSM and ring flag.
// Optional snooze re-ring is compiled in with `define ALARM_SNOOZE_EN.
module time_set_controller
`ifdef ALARM_SNOOZE_EN
  #(parameter int SNOOZE_MIN = 5)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       right,
  input  logic       left,
  input  logic       center,
  input  logic       tick_min,
  output logic [4:0] time_hr,
  output logic [5:0] time_min,
  output logic [4:0] alarm_hr,
  output logic [5:0] alarm_min,
  output logic       adjust_mode,
  output logic [1:0] field_sel,
  output logic       alarm_armed,
  output logic       alarm_ring
);

  typedef enum logic [2:0] {
    CLOCK, ADJ_THR, ADJ_TMIN, ADJ_AHR, ADJ_AMIN
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] thr_q, thr_d, ahr_q, ahr_d;
  logic [5:0] tmin_q, tmin_d, amin_q, amin_d;
  logic       armed_q, armed_d, ring_q, ring_d;
  logic       adj_q, adj_d;
  logic [1:0] fsel_q, fsel_d;
  logic       b_c, b_r, b_l, b_u, b_d;
  logic [4:0] thr_tick;
  logic [5:0] tmin_tick;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_MIN + 1);
  logic [SW-1:0] snz_q, snz_d;
`endif

  function automatic logic [4:0] hr_inc(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [4:0] hr_dec(input logic [4:0] h);
    return (h == 5'd0) ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [5:0] mn_inc(input logic [5:0] m);
    return (m == 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [5:0] mn_dec(input logic [5:0] m);
    return (m == 6'd0) ? 6'd59 : m - 6'd1;
  endfunction

  // One button per cycle; lower-priority pulses are dropped
  always_comb begin
    b_c = center;
    b_r = right & ~center;
    b_l = left & ~center & ~right;
    b_u = up & ~center & ~right & ~left;
    b_d = down & ~center & ~right & ~left & ~up;
  end

  // Time value the minute tick would load
  always_comb begin
    tmin_tick = mn_inc(tmin_q);
    thr_tick  = (tmin_q == 6'd59) ? hr_inc(thr_q) : thr_q;
  end

  // Next-state: mode/field FSM, register edits, ring flag
  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    tmin_d  = tmin_q;
    ahr_d   = ahr_q;
    amin_d  = amin_q;
    armed_d = armed_q;
    ring_d  = ring_q;
`ifdef ALARM_SNOOZE_EN
    snz_d   = snz_q;
`endif
    unique case (state_q)
      CLOCK: begin
        if (tick_min) begin
          thr_d  = thr_tick;
          tmin_d = tmin_tick;
          if (armed_q && thr_tick == ahr_q &&
              tmin_tick == amin_q)
            ring_d = 1'b1;
`ifdef ALARM_SNOOZE_EN
          if (snz_q != '0) begin
            snz_d = snz_q - 1'b1;
            if (snz_q == SW'(1) && armed_q)
              ring_d = 1'b1;
          end
`endif
        end
        if (b_c) begin
          if (ring_q) begin
            ring_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_d  = '0;
`endif
          end else begin
            state_d = ADJ_THR;
          end
        end else if (b_d) begin
          armed_d = ~armed_q;
          if (armed_q) begin
            ring_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_d  = '0;
`endif
          end
        end
`ifdef ALARM_SNOOZE_EN
        else if (b_u && ring_q) begin
          ring_d = 1'b0;
          snz_d  = SW'(SNOOZE_MIN);
        end
`endif
      end
      ADJ_THR: begin
        if (b_c)      state_d = CLOCK;
        else if (b_r) state_d = ADJ_TMIN;
        else if (b_l) state_d = ADJ_AMIN;
        else if (b_u) thr_d = hr_inc(thr_q);
        else if (b_d) thr_d = hr_dec(thr_q);
      end
      ADJ_TMIN: begin
        if (b_c)      state_d = CLOCK;
        else if (b_r) state_d = ADJ_AHR;
        else if (b_l) state_d = ADJ_THR;
        else if (b_u) tmin_d = mn_inc(tmin_q);
        else if (b_d) tmin_d = mn_dec(tmin_q);
      end
      ADJ_AHR: begin
        if (b_c)      state_d = CLOCK;
        else if (b_r) state_d = ADJ_AMIN;
        else if (b_l) state_d = ADJ_TMIN;
        else if (b_u) ahr_d = hr_inc(ahr_q);
        else if (b_d) ahr_d = hr_dec(ahr_q);
      end
      ADJ_AMIN: begin
        if (b_c)      state_d = CLOCK;
        else if (b_r) state_d = ADJ_THR;
        else if (b_l) state_d = ADJ_AHR;
        else if (b_u) amin_d = mn_inc(amin_q);
        else if (b_d) amin_d = mn_dec(amin_q);
      end
      default: state_d = CLOCK;
    endcase
  end

  // Mode outputs decoded from the next state so they stay registered
  always_comb begin
    adj_d  = (state_d != CLOCK);
    fsel_d = 2'd0;
    unique case (state_d)
      ADJ_TMIN: fsel_d = 2'd1;
      ADJ_AHR:  fsel_d = 2'd2;
      ADJ_AMIN: fsel_d = 2'd3;
      default:  fsel_d = 2'd0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLOCK;
      thr_q   <= '0;
      tmin_q  <= '0;
      ahr_q   <= '0;
      amin_q  <= '0;
      armed_q <= 1'b0;
      ring_q  <= 1'b0;
      adj_q   <= 1'b0;
      fsel_q  <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      tmin_q  <= tmin_d;
      ahr_q   <= ahr_d;
      amin_q  <= amin_d;
      armed_q <= armed_d;
      ring_q  <= ring_d;
      adj_q   <= adj_d;
      fsel_q  <= fsel_d;
`ifdef ALARM_SNOOZE_EN
      snz_q   <= snz_d;
`endif
    end
  end

  assign time_hr     = thr_q;
  assign time_min    = tmin_q;
  assign alarm_hr    = ahr_q;
  assign alarm_min   = amin_q;
  assign adjust_mode = adj_q;
  assign field_sel   = fsel_q;
  assign alarm_armed = armed_q;
  assign alarm_ring  = ring_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller.
// Inputs driven at negedge, outputs checked 1 time unit after posedge.
module tb_time_set_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 0, down = 0, right = 0, left = 0;
  logic       center = 0, tick_min = 0;
  logic [4:0] time_hr, alarm_hr;
  logic [5:0] time_min, alarm_min;
  logic       adjust_mode, alarm_armed, alarm_ring;
  logic [1:0] field_sel;

  int vectors = 0;
  int miscompares = 0;

  time_set_controller dut (
    .clk(clk), .rst(rst),
    .up(up), .down(down), .right(right),
    .left(left), .center(center),
    .tick_min(tick_min),
    .time_hr(time_hr), .time_min(time_min),
    .alarm_hr(alarm_hr), .alarm_min(alarm_min),
    .adjust_mode(adjust_mode),
    .field_sel(field_sel),
    .alarm_armed(alarm_armed),
    .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic press(input logic u, input logic d,
                       input logic r, input logic l,
                       input logic c, input logic t);
    @(negedge clk);
    up = u; down = d; right = r;
    left = l; center = c; tick_min = t;
    @(posedge clk);
    #1;
    up = 0; down = 0; right = 0;
    left = 0; center = 0; tick_min = 0;
  endtask

  task automatic p_up();     press(1,0,0,0,0,0); endtask
  task automatic p_down();   press(0,1,0,0,0,0); endtask
  task automatic p_right();  press(0,0,1,0,0,0); endtask
  task automatic p_left();   press(0,0,0,1,0,0); endtask
  task automatic p_center(); press(0,0,0,0,1,0); endtask
  task automatic p_tick();   press(0,0,0,0,0,1); endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_thr"},  8'(time_hr), 8'd0);
    chk({pfx, "_tmin"}, 8'(time_min), 8'd0);
    chk({pfx, "_ahr"},  8'(alarm_hr), 8'd0);
    chk({pfx, "_amin"}, 8'(alarm_min), 8'd0);
    chk({pfx, "_arm"},  8'(alarm_armed), 8'd0);
    chk({pfx, "_ring"}, 8'(alarm_ring), 8'd0);
    chk({pfx, "_adj"},  8'(adjust_mode), 8'd0);
    chk({pfx, "_fsel"}, 8'(field_sel), 8'd0);
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk_zero("por");
    @(negedge clk);
    rst = 1'b0;

    // Preset 12:34 in ADJ_AMIN, then async reset mid-cycle
    p_center();
    chk("enter_adj", 8'(adjust_mode), 8'd1);
    chk("enter_fsel", 8'(field_sel), 8'd0);
    repeat (12) p_up();
    p_right();
    repeat (34) p_up();
    p_right();
    p_right();
    chk("pre_thr", 8'(time_hr), 8'd12);
    chk("pre_tmin", 8'(time_min), 8'd34);
    chk("pre_fsel", 8'(field_sel), 8'd3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("arst");
    @(negedge clk);
    rst = 1'b0;

    // Edit wraps: hr 0->23, min 59->0 without carry
    p_center();
    p_down();
    chk("hr_wrap_dn", 8'(time_hr), 8'd23);
    p_right();
    p_down();
    chk("min_wrap_dn", 8'(time_min), 8'd59);
    p_up();
    chk("min_wrap_up", 8'(time_min), 8'd0);
    chk("no_carry", 8'(time_hr), 8'd23);
    p_left();
    chk("left_fsel", 8'(field_sel), 8'd0);
    p_right();
    p_down();
    p_center();
    chk("exit_adj", 8'(adjust_mode), 8'd0);
    chk("exit_fsel", 8'(field_sel), 8'd0);
    chk("pre_2359_h", 8'(time_hr), 8'd23);
    chk("pre_2359_m", 8'(time_min), 8'd59);
    p_tick();
    chk("midnight_h", 8'(time_hr), 8'd0);
    chk("midnight_m", 8'(time_min), 8'd0);

    // Alarm 07:00, armed, time 06:59
    p_center();
    p_right();
    p_right();
    chk("ahr_fsel", 8'(field_sel), 8'd2);
    repeat (7) p_up();
    chk("alarm_hr", 8'(alarm_hr), 8'd7);
    chk("alarm_min", 8'(alarm_min), 8'd0);
    p_center();
    p_down();
    chk("armed", 8'(alarm_armed), 8'd1);
    p_center();
    repeat (6) p_up();
    p_right();
    p_down();
    p_center();
    chk("t659_h", 8'(time_hr), 8'd6);
    chk("t659_m", 8'(time_min), 8'd59);
    chk("no_ring_yet", 8'(alarm_ring), 8'd0);
    p_tick();
    chk("t700_h", 8'(time_hr), 8'd7);
    chk("t700_m", 8'(time_min), 8'd0);
    chk("ring_set", 8'(alarm_ring), 8'd1);
    p_center();
    chk("ring_dismiss", 8'(alarm_ring), 8'd0);
    chk("dismiss_adj", 8'(adjust_mode), 8'd0);
    chk("still_armed", 8'(alarm_armed), 8'd1);

    // center + up same cycle: enter ADJ_THR, up dropped
    press(1,0,0,0,1,0);
    chk("cu_adj", 8'(adjust_mode), 8'd1);
    chk("cu_fsel", 8'(field_sel), 8'd0);
    chk("cu_thr", 8'(time_hr), 8'd7);
    p_tick();
    p_tick();
    chk("frz_h", 8'(time_hr), 8'd7);
    chk("frz_m", 8'(time_min), 8'd0);
    p_down();
    p_up();
    chk("edit_match_h", 8'(time_hr), 8'd7);
    chk("edit_no_ring", 8'(alarm_ring), 8'd0);
    press(1,0,1,0,0,0);
    chk("ru_fsel", 8'(field_sel), 8'd1);
    chk("ru_tmin", 8'(time_min), 8'd0);
    press(1,1,0,1,0,0);
    chk("lud_fsel", 8'(field_sel), 8'd0);
    chk("lud_thr", 8'(time_hr), 8'd7);

    // Alarm 07:01, ring on next tick
    p_right();
    p_right();
    p_right();
    chk("amin_fsel", 8'(field_sel), 8'd3);
    p_up();
    chk("alarm_min1", 8'(alarm_min), 8'd1);
    p_center();
    p_tick();
    chk("t701_m", 8'(time_min), 8'd1);
    chk("ring2", 8'(alarm_ring), 8'd1);

`ifdef ALARM_SNOOZE_EN
    p_up();
    chk("snooze_clr", 8'(alarm_ring), 8'd0);
    for (int i = 1; i <= 4; i++) begin
      p_tick();
      chk("snooze_wait", 8'(alarm_ring), 8'd0);
    end
    p_tick();
    chk("snooze_m", 8'(time_min), 8'd6);
    chk("snooze_ring", 8'(alarm_ring), 8'd1);
`else
    p_up();
    chk("up_ignored", 8'(alarm_ring), 8'd1);
    chk("up_no_adj", 8'(adjust_mode), 8'd0);
    chk("up_tmin", 8'(time_min), 8'd1);
`endif

    // Disarm clears ring; no ring while disarmed
    p_down();
    chk("disarm", 8'(alarm_armed), 8'd0);
    chk("disarm_ring", 8'(alarm_ring), 8'd0);
    p_tick();
    chk("disarm_tick", 8'(alarm_ring), 8'd0);
    p_down();
    chk("rearm", 8'(alarm_armed), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
